bist_seq_ctrl: RTL and testbench
================================

# bist_seq_ctrl

Built-in self-test sequencer for the SRAM macro. It runs a bank of deterministic open-loop pattern generators one at a time and muxes the selected generator's address, data, mask and strobes onto the SRAM port. It compares each read against the generator's expected word and reports pass/fail, a saturating error count and optional first-failure details. It sits between the test-mode CSRs (start, select, status) and the SRAM's single read/write port.

## Interface
Parameters:
- NUM_PG, 4, number of pattern generators (1–16)
- MAX_ADDR, 256, SRAM depth
- ADDR_WIDTH, $clog2(MAX_ADDR), address width
- DATA_WIDTH, 32, word width
- MASK_WIDTH, 4, write-mask width
- CNT_WIDTH, 16, error-counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rstb  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle start pulse
- pg_sel  in  NUM_PG  generators to run, bit i = generator i
- pg_en  out  NUM_PG  per-generator advance enable
- pg_rst  out  NUM_PG  per-generator reset, active-high
- pg_addr  in  NUM_PG*ADDR_WIDTH  packed generator addresses
- pg_data  in  NUM_PG*DATA_WIDTH  packed write data
- pg_check  in  NUM_PG*DATA_WIDTH  packed expected read data
- pg_wmask  in  NUM_PG*MASK_WIDTH  packed write masks
- pg_we, pg_re, pg_done  in  NUM_PG each  generator strobes
- sram_ce, sram_we  out  1  SRAM chip enable / write enable
- sram_addr  out  ADDR_WIDTH; sram_din  out  DATA_WIDTH; sram_wmask  out  MASK_WIDTH
- sram_dout  in  DATA_WIDTH  read data, valid one cycle after a read cycle
- busy, done, fail  out  1  status
- err_count  out  CNT_WIDTH  saturating mismatch count
- fail_pg  out  $clog2(NUM_PG) (min 1); fail_addr  out  ADDR_WIDTH; fail_data  out  DATA_WIDTH  first-failure record

## Operation
- States: IDLE, PGRST, RUN, DRAIN, DONE.
- IDLE:
  - start=1 clears err_count, fail and the fail_* outputs, then latches pg_sel.
  - If the latched mask is nonzero, go to PGRST with cur = lowest set bit.
  - If the mask is zero, go straight to DONE.
- PGRST: one cycle. pg_rst[cur]=1 and all pg_en=0. Next state is RUN.
- RUN:
  - pg_en[cur]=1.
  - SRAM outputs are a combinational mux of generator cur: sram_ce = pg_we|pg_re; sram_we = pg_we; addr, din and wmask pass through.
  - When pg_done[cur] is sampled high, that cycle's transaction is still issued, then the state goes to DRAIN.
- DRAIN: one cycle with no SRAM access, so the last read is compared. Then go to PGRST with cur = next set bit above cur, or to DONE if none remains.
- DONE: done=1, busy=0. start=1 restarts as in IDLE.
- Outside RUN: sram_ce=0, sram_we=0, and addr/din/wmask are 0.
- Compare pipeline:
  - Any RUN cycle with re issued registers rd_v=1 together with check, addr and cur.
  - The next cycle compares sram_dout against the registered check over the full word.
  - On mismatch: fail=1 (sticky), err_count increments and saturates at all-ones.
  - The first mismatch since start captures fail_pg, fail_addr and fail_data (the observed sram_dout).
- start while busy is ignored.
- pg_we and pg_re both high in the same cycle is a generator fault. Treat it as a write only, with no compare.
- pg_sel changes after start have no effect.

## Timing
- Reset values: all outputs 0. State is IDLE, err_count=0, fail=0, done=0, busy=0.
- Assertion of rstb=0 mid-test aborts immediately (asynchronous). Release returns to IDLE.
- start sampled at edge T:
  - PGRST occupies cycle T+1.
  - First RUN cycle is T+2.
  - busy is high from T+1 until DONE.
- Read latency 1: a read issued in cycle k is compared in cycle k+1. err_count and fail update at edge k+2.
- A read issued in a generator's last RUN cycle is compared during DRAIN.
- Per-generator overhead: 2 cycles (PGRST + DRAIN). done rises the cycle after the final DRAIN.

## Configuration
- BIST_FAIL_LOG_EN defined: fail_pg, fail_addr and fail_data capture the first mismatch as described, including the pipeline copies of addr and cur.
- BIST_FAIL_LOG_EN undefined: fail_pg, fail_addr and fail_data are tied to 0 and their capture registers are removed. fail and err_count are unchanged.

## Test plan
- Single generator, pg_sel=4'b0001, 4-word write then read, model SRAM correct:
  - pg_rst[0] pulses at T+1, first sram_ce at T+2.
  - done=1, fail=0, err_count=0.
- pg_sel=4'b1010:
  - Generators 1 then 3 run with one PGRST and one DRAIN cycle each.
  - pg_en[0] and pg_en[2] never assert.
- Model SRAM flips bit 0 at addr 5, then at addr 9:
  - fail=1, err_count=2.
  - With the macro: fail_addr=5, fail_data = check^1, fail_pg = running index.
- pg_sel=0, start → done=1 at T+1, no sram_ce, no pg_rst.
- Stuck SRAM returning 0 on every read, CNT_WIDTH=4, 20 mismatched reads → err_count=15 (saturated).
- rstb low in the middle of RUN → all outputs 0 asynchronously. After release, start reruns cleanly with err_count cleared.

Source files
------------

// File: rtl/bist_seq_ctrl.sv
// bist_seq_ctrl: SRAM built-in self-test sequencer.
// Runs the selected pattern generators one after another (lowest index first),
// muxes the active generator onto the single SRAM port and checks every read
// one cycle later against the generator's expected word.
// Optional feature macro: BIST_FAIL_LOG_EN enables the first-failure record
// (fail_pg / fail_addr / fail_data); without it those outputs are tied to 0.
module bist_seq_ctrl #(
    parameter int NUM_PG     = 4,
    parameter int MAX_ADDR   = 256,
    parameter int ADDR_WIDTH = $clog2(MAX_ADDR),
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int PG_W      = (NUM_PG > 1) ? $clog2(NUM_PG) : 1
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             start,
    input  logic [NUM_PG-1:0]                pg_sel,
    output logic [NUM_PG-1:0]                pg_en,
    output logic [NUM_PG-1:0]                pg_rst,
    input  logic [NUM_PG*ADDR_WIDTH-1:0]     pg_addr,
    input  logic [NUM_PG*DATA_WIDTH-1:0]     pg_data,
    input  logic [NUM_PG*DATA_WIDTH-1:0]     pg_check,
    input  logic [NUM_PG*MASK_WIDTH-1:0]     pg_wmask,
    input  logic [NUM_PG-1:0]                pg_we,
    input  logic [NUM_PG-1:0]                pg_re,
    input  logic [NUM_PG-1:0]                pg_done,
    output logic                             sram_ce,
    output logic                             sram_we,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    output logic [DATA_WIDTH-1:0]            sram_din,
    output logic [MASK_WIDTH-1:0]            sram_wmask,
    input  logic [DATA_WIDTH-1:0]            sram_dout,
    output logic                             busy,
    output logic                             done,
    output logic                             fail,
    output logic [CNT_WIDTH-1:0]             err_count,
    output logic [PG_W-1:0]                  fail_pg,
    output logic [ADDR_WIDTH-1:0]            fail_addr,
    output logic [DATA_WIDTH-1:0]            fail_data
);

    typedef enum logic [2:0] {S_IDLE, S_PGRST, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [NUM_PG-1:0]       r_sel;
    logic [PG_W-1:0]         r_cur, w_cur_nxt;
    logic                    w_start_acc;
    logic                    w_first_vld, w_next_vld;
    logic [PG_W-1:0]         w_first_idx, w_next_idx;

    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [DATA_WIDTH-1:0]   w_sel_check;
    logic [MASK_WIDTH-1:0]   w_sel_wmask;
    logic                    w_sel_we, w_sel_re, w_sel_done;
    logic                    w_rd_issue, w_mismatch;

    logic                    r_vld_p0;
    logic [DATA_WIDTH-1:0]   r_chk_p0;
    logic                    r_fail;
    logic [CNT_WIDTH-1:0]    r_err_cnt;

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign w_sel_addr  = pg_addr [int'(r_cur)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_data  = pg_data [int'(r_cur)*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_check = pg_check[int'(r_cur)*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_wmask = pg_wmask[int'(r_cur)*MASK_WIDTH +: MASK_WIDTH];
    assign w_sel_we    = pg_we[r_cur];
    assign w_sel_re    = pg_re[r_cur];
    assign w_sel_done  = pg_done[r_cur];

    // Priority search: lowest bit of the incoming select, next selected bit above cur.
    always_comb begin
        w_first_vld = 1'b0;
        w_first_idx = '0;
        w_next_vld  = 1'b0;
        w_next_idx  = '0;
        for (int i = NUM_PG - 1; i >= 0; i--) begin
            if (pg_sel[i]) begin
                w_first_vld = 1'b1;
                w_first_idx = PG_W'(i);
            end
            if (r_sel[i] && (i > int'(r_cur))) begin
                w_next_vld = 1'b1;
                w_next_idx = PG_W'(i);
            end
        end
    end

    // FSM state register plus latched generator mask and current index.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            if (w_start_acc) r_sel <= pg_sel;
        end
    end

    // FSM next-state: start is only honoured from IDLE or DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    if (w_first_vld) begin
                        w_state_nxt = S_PGRST;
                        w_cur_nxt   = w_first_idx;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_PGRST: w_state_nxt = S_RUN;
            S_RUN:   if (w_sel_done) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (w_next_vld) begin
                    w_state_nxt = S_PGRST;
                    w_cur_nxt   = w_next_idx;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: generator controls, SRAM port mux and status flags.
    always_comb begin
        pg_en      = '0;
        pg_rst     = '0;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_din   = '0;
        sram_wmask = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_PGRST: begin
                pg_rst[r_cur] = 1'b1;
                busy          = 1'b1;
            end
            S_RUN: begin
                pg_en[r_cur] = 1'b1;
                busy         = 1'b1;
                sram_ce      = w_sel_we | w_sel_re;
                sram_we      = w_sel_we;
                sram_addr    = w_sel_addr;
                sram_din     = w_sel_data;
                sram_wmask   = w_sel_wmask;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // A cycle with both strobes set is a generator fault: it goes out as a write, never compared.
    assign w_rd_issue = (r_state == S_RUN) && w_sel_re && !w_sel_we;

    // ---- stage p0: read issued, expected word registered alongside it ----
    // Read-valid control bit.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) r_vld_p0 <= 1'b0;
        else       r_vld_p0 <= w_rd_issue;
    end

    // Expected-word pipeline copy; qualified by r_vld_p0 so it needs no reset.
    always_ff @(posedge clk) begin
        r_chk_p0 <= w_sel_check;
    end

    // ---- stage p1: sram_dout valid, compared against the registered check ----
    assign w_mismatch = r_vld_p0 && (sram_dout != r_chk_p0);

    // Sticky fail flag and saturating error counter, cleared on an accepted start.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_fail    <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_start_acc) begin
            r_fail    <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_mismatch) begin
            r_fail    <= 1'b1;
            r_err_cnt <= f_sat_inc(r_err_cnt);
        end
    end

    assign fail      = r_fail;
    assign err_count = r_err_cnt;

`ifdef BIST_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] r_addr_p0;
    logic [PG_W-1:0]       r_pg_p0;
    logic [PG_W-1:0]       r_fail_pg;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_data;

    // Address and generator index travel with the expected word.
    always_ff @(posedge clk) begin
        r_addr_p0 <= w_sel_addr;
        r_pg_p0   <= r_cur;
    end

    // First mismatch since start is recorded; r_fail still low marks it as the first.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_fail_pg   <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else if (w_start_acc) begin
            r_fail_pg   <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else if (w_mismatch && !r_fail) begin
            r_fail_pg   <= r_pg_p0;
            r_fail_addr <= r_addr_p0;
            r_fail_data <= sram_dout;
        end
    end

    assign fail_pg   = r_fail_pg;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
`else
    assign fail_pg   = '0;
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Bench for bist_seq_ctrl: behavioural pattern generators and a model SRAM,
// expected SRAM transactions queued per run and popped as the DUT issues them.
module tb_bist_seq_ctrl;

    localparam int NPG = 4;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int MW  = 4;
    localparam int CW  = 4;

    logic               clk = 1'b0;
    logic               rstb = 1'b0;
    logic               start = 1'b0;
    logic [NPG-1:0]     pg_sel = '0;
    logic [NPG-1:0]     pg_en, pg_rst;
    logic [NPG*AW-1:0]  pg_addr;
    logic [NPG*DW-1:0]  pg_data, pg_check;
    logic [NPG*MW-1:0]  pg_wmask;
    logic [NPG-1:0]     pg_we, pg_re, pg_done;
    logic               sram_ce, sram_we;
    logic [AW-1:0]      sram_addr;
    logic [DW-1:0]      sram_din;
    logic [MW-1:0]      sram_wmask;
    logic [DW-1:0]      sram_dout;
    logic               busy, done, fail;
    logic [CW-1:0]      err_count;
    logic [1:0]         fail_pg;
    logic [AW-1:0]      fail_addr;
    logic [DW-1:0]      fail_data;

    bist_seq_ctrl #(
        .NUM_PG(NPG), .MAX_ADDR(256), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MASK_WIDTH(MW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rstb(rstb), .start(start), .pg_sel(pg_sel),
        .pg_en(pg_en), .pg_rst(pg_rst), .pg_addr(pg_addr), .pg_data(pg_data),
        .pg_check(pg_check), .pg_wmask(pg_wmask), .pg_we(pg_we), .pg_re(pg_re),
        .pg_done(pg_done), .sram_ce(sram_ce), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_wmask(sram_wmask),
        .sram_dout(sram_dout), .busy(busy), .done(done), .fail(fail),
        .err_count(err_count), .fail_pg(fail_pg), .fail_addr(fail_addr),
        .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- pattern generators: n writes to 0..n-1, then n reads back
    int   gen_n     [NPG] = '{4, 4, 4, 4};
    int   gen_idx   [NPG] = '{0, 0, 0, 0};
    logic gen_fault [NPG] = '{1'b0, 1'b0, 1'b0, 1'b0};

    function automatic logic [DW-1:0] wdat(input int g, input int k);
        return 32'hA500_0000 | 32'(g << 16) | 32'(k);
    endfunction

    always_comb begin
        pg_addr  = '0;
        pg_data  = '0;
        pg_check = '0;
        pg_wmask = '0;
        pg_we    = '0;
        pg_re    = '0;
        pg_done  = '0;
        for (int g = 0; g < NPG; g++) begin
            pg_wmask[g*MW +: MW] = '1;
            if (gen_idx[g] < gen_n[g]) begin
                pg_we[g]             = 1'b1;
                pg_re[g]             = gen_fault[g] && (gen_idx[g] == 0);
                pg_addr[g*AW +: AW]  = AW'(gen_idx[g]);
                pg_data[g*DW +: DW]  = wdat(g, gen_idx[g]);
                pg_check[g*DW +: DW] = 32'hDEAD_BEEF;
            end else begin
                pg_re[g]             = 1'b1;
                pg_addr[g*AW +: AW]  = AW'(gen_idx[g] - gen_n[g]);
                pg_check[g*DW +: DW] = wdat(g, gen_idx[g] - gen_n[g]);
            end
            pg_done[g] = (gen_idx[g] == 2 * gen_n[g] - 1);
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < NPG; g++) begin
            if (pg_rst[g]) gen_idx[g] <= 0;
            else if (pg_en[g] && gen_idx[g] < 2 * gen_n[g] - 1) gen_idx[g] <= gen_idx[g] + 1;
        end
    end

    // ---------------- model SRAM with fault injection
    logic [DW-1:0] mem [256];
    logic sram_stuck = 1'b0;
    logic sram_flip  = 1'b0;

    always @(posedge clk) begin
        if (sram_ce && sram_we) begin
            for (int b = 0; b < MW; b++)
                if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
        end else if (sram_ce) begin
            if (sram_stuck) sram_dout <= '0;
            else if (sram_flip && (sram_addr == 8'd5 || sram_addr == 8'd9))
                sram_dout <= mem[sram_addr] ^ 32'h1;
            else sram_dout <= mem[sram_addr];
        end
    end

    // ---------------- scoreboard
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_e;
    logic [NPG-1:0] en_allow = '0;

    task automatic push_exp(input logic [NPG-1:0] sel);
        txn_t t;
        for (int g = 0; g < NPG; g++) begin
            if (sel[g]) begin
                for (int k = 0; k < 2 * gen_n[g]; k++) begin
                    t.we   = (k < gen_n[g]);
                    t.addr = (k < gen_n[g]) ? AW'(k) : AW'(k - gen_n[g]);
                    t.din  = (k < gen_n[g]) ? wdat(g, k) : '0;
                    exp_q.push_back(t);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rstb && sram_ce) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sram_txn unexpected access addr=%0d we=%0b", sram_addr, sram_we);
            end else begin
                mon_e = exp_q.pop_front();
                if (sram_we !== mon_e.we || sram_addr !== mon_e.addr ||
                    (mon_e.we && sram_din !== mon_e.din)) begin
                    errors++;
                    $display("FAIL sram_txn got we=%0b addr=%0d din=%h required we=%0b addr=%0d din=%h",
                             sram_we, sram_addr, sram_din, mon_e.we, mon_e.addr, mon_e.din);
                end
            end
        end
        if (rstb && busy) begin
            checks++;
            if ((pg_en & ~en_allow) !== '0) begin
                errors++;
                $display("FAIL pg_en_unselected got %b allowed %b", pg_en, en_allow);
            end
        end
    end

    // ---------------- stimulus helpers (no checking inside)
    task automatic kick(input logic [NPG-1:0] sel);
        @(negedge clk);
        pg_sel = sel;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // c counts clock edges from the start edge (inclusive); capped so a hang cannot stall the run.
    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (done !== 1'b1 && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    // ---------------- tests
    task automatic test_reset();
        rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, fail} !== 3'b000) begin
            errors++; $display("FAIL rst_status got busy/done/fail=%b required 000", {busy, done, fail});
        end
        checks++;
        if (err_count !== '0) begin
            errors++; $display("FAIL rst_err_count got %0d required 0", err_count);
        end
        checks++;
        if ({sram_ce, sram_we, sram_addr, sram_din, sram_wmask} !== '0) begin
            errors++; $display("FAIL rst_sram got ce=%b addr=%h din=%h required all 0", sram_ce, sram_addr, sram_din);
        end
        checks++;
        if ({pg_en, pg_rst} !== '0) begin
            errors++; $display("FAIL rst_pg got en=%b rst=%b required 0", pg_en, pg_rst);
        end
        checks++;
        if ({fail_pg, fail_addr, fail_data} !== '0) begin
            errors++; $display("FAIL rst_fail_log got pg=%0d addr=%0d data=%h required 0", fail_pg, fail_addr, fail_data);
        end
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_single();
        int c;
        gen_n[0] = 4;
        en_allow = 4'b0001;
        push_exp(4'b0001);
        kick(4'b0001);
        checks++;
        if (pg_rst !== 4'b0001 || busy !== 1'b1 || sram_ce !== 1'b0) begin
            errors++; $display("FAIL single_pgrst got pg_rst=%b busy=%b ce=%b required 0001 1 0", pg_rst, busy, sram_ce);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sram_ce !== 1'b1 || pg_en !== 4'b0001 || pg_rst !== 4'b0000) begin
            errors++; $display("FAIL single_first_run got ce=%b pg_en=%b pg_rst=%b required 1 0001 0000", sram_ce, pg_en, pg_rst);
        end
        wait_done(2, c);
        checks++;
        if (c != 11) begin
            errors++; $display("FAIL single_done_cycle got %0d required 11", c);
        end
        checks++;
        if (fail !== 1'b0 || err_count !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_status got fail=%b err=%0d busy=%b required 0 0 0", fail, err_count, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL single_txn_left got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_two_gens();
        int c;
        gen_n[1]     = 3;
        gen_n[3]     = 5;
        gen_fault[3] = 1'b1;
        en_allow     = 4'b1010;
        push_exp(4'b1010);
        kick(4'b1010);
        // start again while busy, with a different select: must be ignored
        @(negedge clk);
        pg_sel = 4'b1111;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        wait_done(2, c);
        checks++;
        if (c != 21) begin
            errors++; $display("FAIL two_done_cycle got %0d required 21", c);
        end
        checks++;
        if (fail !== 1'b0 || err_count !== '0) begin
            errors++; $display("FAIL two_status got fail=%b err=%0d required 0 0", fail, err_count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL two_txn_left got %0d required 0", exp_q.size());
        end
        gen_fault[3] = 1'b0;
    endtask

    task automatic test_bit_flip();
        int c;
        logic [DW-1:0] exp_data;
        gen_n[1]  = 12;
        sram_flip = 1'b1;
        en_allow  = 4'b0010;
        push_exp(4'b0010);
        kick(4'b0010);
        wait_done(1, c);
        checks++;
        if (c != 27) begin
            errors++; $display("FAIL flip_done_cycle got %0d required 27", c);
        end
        checks++;
        if (fail !== 1'b1 || err_count !== 4'd2) begin
            errors++; $display("FAIL flip_status got fail=%b err=%0d required 1 2", fail, err_count);
        end
`ifdef BIST_FAIL_LOG_EN
        exp_data = wdat(1, 5) ^ 32'h1;
        checks++;
        if (fail_pg !== 2'd1 || fail_addr !== 8'd5 || fail_data !== exp_data) begin
            errors++; $display("FAIL flip_log got pg=%0d addr=%0d data=%h required 1 5 %h", fail_pg, fail_addr, fail_data, exp_data);
        end
`else
        exp_data = '0;
        checks++;
        if ({fail_pg, fail_addr, fail_data} !== '0) begin
            errors++; $display("FAIL flip_log got pg=%0d addr=%0d data=%h required 0 0 %h", fail_pg, fail_addr, fail_data, exp_data);
        end
`endif
        sram_flip = 1'b0;
    endtask

    task automatic test_zero_sel();
        en_allow = '0;
        kick(4'b0000);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pg_rst !== '0 || sram_ce !== 1'b0) begin
            errors++; $display("FAIL zero_done got done=%b busy=%b pg_rst=%b ce=%b required 1 0 0 0", done, busy, pg_rst, sram_ce);
        end
        checks++;
        if (fail !== 1'b0 || err_count !== '0 || {fail_pg, fail_addr, fail_data} !== '0) begin
            errors++; $display("FAIL zero_cleared got fail=%b err=%0d addr=%0d required 0 0 0", fail, err_count, fail_addr);
        end
    endtask

    task automatic test_saturate();
        int c;
        gen_n[0]   = 20;
        sram_stuck = 1'b1;
        en_allow   = 4'b0001;
        push_exp(4'b0001);
        kick(4'b0001);
        wait_done(1, c);
        checks++;
        if (c != 43) begin
            errors++; $display("FAIL sat_done_cycle got %0d required 43", c);
        end
        checks++;
        if (fail !== 1'b1 || err_count !== 4'd15) begin
            errors++; $display("FAIL sat_err_count got fail=%b err=%0d required 1 15", fail, err_count);
        end
`ifdef BIST_FAIL_LOG_EN
        checks++;
        if (fail_pg !== 2'd0 || fail_addr !== 8'd0 || fail_data !== '0) begin
            errors++; $display("FAIL sat_log got pg=%0d addr=%0d data=%h required 0 0 0", fail_pg, fail_addr, fail_data);
        end
`endif
        sram_stuck = 1'b0;
    endtask

    task automatic test_abort();
        int c;
        gen_n[0]   = 20;
        sram_stuck = 1'b1;
        en_allow   = 4'b0001;
        push_exp(4'b0001);
        kick(4'b0001);
        repeat (28) @(posedge clk);
        #2;
        checks++;
        if (err_count === '0 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_pre got err=%0d busy=%b required nonzero 1", err_count, busy);
        end
        rstb = 1'b0;
        #1;
        checks++;
        if ({busy, done, fail, err_count, sram_ce, sram_we, sram_addr, sram_din, pg_en, pg_rst} !== '0) begin
            errors++; $display("FAIL abort_async got busy=%b ce=%b err=%0d pg_en=%b required all 0", busy, sram_ce, err_count, pg_en);
        end
        exp_q.delete();
        sram_stuck = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        gen_n[0] = 4;
        push_exp(4'b0001);
        kick(4'b0001);
        wait_done(1, c);
        checks++;
        if (c != 11) begin
            errors++; $display("FAIL rerun_done_cycle got %0d required 11", c);
        end
        checks++;
        if (fail !== 1'b0 || err_count !== '0) begin
            errors++; $display("FAIL rerun_status got fail=%b err=%0d required 0 0", fail, err_count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rerun_txn_left got %0d required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_gens();
        test_bit_flip();
        test_zero_sel();
        test_saturate();
        test_abort();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
